// File: rtl/imem_dmem_arbiter.sv
// Shares the unified single-port instruction/data memory between boot loader, fetch and data.
// Sequences BOOT->RUN, grants one access per cycle and routes registered read data back.
module imem_dmem_arbiter #(
   parameter int unsigned MEM_DEPTH  = 100,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        res,
   input  logic        ld_req,
   input  logic [31:0] ld_adr,
   input  logic [31:0] ld_data,
   input  logic        boot_done,
   output logic        ld_gnt,
   input  logic        if_req,
   input  logic [31:0] if_adr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_adr,
   input  logic [31:0] dm_wd,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   output logic        mem_instr_en,
   output logic [31:0] mem_mem_adr,
   output logic [31:0] mem_mem_in,
   input  logic [31:0] mem_rd,
   output logic        running,
   output logic        adr_err
);

   typedef enum logic {BOOT, RUN} state_t;

   localparam logic [31:0] DEPTH   = 32'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   state_t           r_state;
   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_adr_err;
   logic             r_if_rvalid;
   logic             r_dm_rvalid;
   logic             r_rd_oob;

   logic w_ld_ok, w_if_ok, w_dm_ok, w_force_if, w_oob;

   assign w_ld_ok    = (ld_adr < DEPTH);
   assign w_if_ok    = (if_adr < DEPTH);
   assign w_dm_ok    = (dm_adr < DEPTH);
   assign w_force_if = (r_starve_cnt == CNT_MAX);

   always_comb begin
      ld_gnt       = 1'b0;
      if_gnt       = 1'b0;
      dm_gnt       = 1'b0;
      mem_a        = '0;
      mem_wd       = '0;
      mem_we       = 1'b0;
      mem_instr_en = 1'b0;
      mem_mem_adr  = '0;
      mem_mem_in   = '0;
      if (!res) begin
         if (r_state == BOOT) begin
            ld_gnt = ld_req;
            if (ld_req && w_ld_ok) begin
               mem_instr_en = 1'b1;
               mem_mem_adr  = ld_adr;
               mem_mem_in   = ld_data;
            end
         end else begin
            // data wins unless fetch has been starved STARVE_MAX times in a row
            if (if_req && (w_force_if || !dm_req)) if_gnt = 1'b1;
            else if (dm_req)                       dm_gnt = 1'b1;
            if (if_gnt && w_if_ok) mem_a = if_adr;
            if (dm_gnt && w_dm_ok) begin
               mem_a = dm_adr;
               if (dm_we) begin
                  mem_we = 1'b1;
                  mem_wd = dm_wd;
               end
            end
         end
      end
   end

   assign w_oob = (ld_gnt && !w_ld_ok) || (if_gnt && !w_if_ok) || (dm_gnt && !w_dm_ok);

   always_ff @(posedge clk) begin
      if (res) begin
         r_state      <= BOOT;
         r_starve_cnt <= '0;
         r_adr_err    <= 1'b0;
         r_if_rvalid  <= 1'b0;
         r_dm_rvalid  <= 1'b0;
         r_rd_oob     <= 1'b0;
      end else begin
         r_if_rvalid <= if_gnt;
         r_dm_rvalid <= dm_gnt && !dm_we;
         r_rd_oob    <= (if_gnt && !w_if_ok) || (dm_gnt && !w_dm_ok);
         if (w_oob) r_adr_err <= 1'b1;
         if (r_state == BOOT) begin
            if (boot_done) r_state <= RUN;
         end else if (if_gnt || !if_req) begin
            r_starve_cnt <= '0;
         end else if (dm_gnt && r_starve_cnt != CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

   // rvalid is masked by res so a read in flight when reset arrives never reports
   assign if_rvalid = r_if_rvalid && !res;
   assign dm_rvalid = r_dm_rvalid && !res;
   assign if_rdata  = (if_rvalid && !r_rd_oob) ? mem_rd : '0;
   assign dm_rdata  = (dm_rvalid && !r_rd_oob) ? mem_rd : '0;
   assign running   = (r_state == RUN);
   assign adr_err   = r_adr_err;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized bench for imem_dmem_arbiter: a behavioural memory plus a rule-level model
// of arbitration, starvation and read return checks every output every cycle.
module tb_imem_dmem_arbiter;

   localparam int DEPTH      = 100;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        res, ld_req, boot_done, if_req, dm_req, dm_we;
   logic [31:0] ld_adr, ld_data, if_adr, dm_adr, dm_wd, mem_rd;
   logic        ld_gnt, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_we, mem_instr_en;
   logic        running, adr_err;
   logic [31:0] if_rdata, dm_rdata, mem_a, mem_wd, mem_mem_adr, mem_mem_in;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   bit          m_run, m_err, m_if_rv, m_dm_rv;
   int          m_starve;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.MEM_DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
      .clk(clk), .res(res),
      .ld_req(ld_req), .ld_adr(ld_adr), .ld_data(ld_data), .boot_done(boot_done), .ld_gnt(ld_gnt),
      .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wd(dm_wd), .dm_gnt(dm_gnt),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_instr_en(mem_instr_en),
      .mem_mem_adr(mem_mem_adr), .mem_mem_in(mem_mem_in), .mem_rd(mem_rd),
      .running(running), .adr_err(adr_err)
   );

   // single-port memory with registered read
   always @(posedge clk) begin
      if (mem_instr_en && mem_mem_adr < DEPTH) mem[mem_mem_adr[6:0]] <= mem_mem_in;
      if (mem_we && mem_a < DEPTH) mem[mem_a[6:0]] <= mem_wd;
      mem_rd <= (mem_a < DEPTH) ? mem[mem_a[6:0]] : 32'h0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      res = 0; ld_req = 0; boot_done = 0; if_req = 0; dm_req = 0; dm_we = 0;
      ld_adr = 0; ld_data = 0; if_adr = 0; dm_adr = 0; dm_wd = 0;
   endtask

   // Check one cycle against the model, then advance model and clock.
   task automatic tick();
      bit e_ld, e_if, e_dm, e_we, e_ien, rv_ok;
      logic [31:0] e_a, e_wd, e_madr, e_min, radr;
      #1;
      e_ld = 0; e_if = 0; e_dm = 0; e_we = 0; e_ien = 0;
      e_a = 0; e_wd = 0; e_madr = 0; e_min = 0;
      if (!res) begin
         if (!m_run) begin
            e_ld = ld_req;
            if (ld_req && ld_adr < DEPTH) begin
               e_ien = 1; e_madr = ld_adr; e_min = ld_data;
            end
         end else begin
            if (if_req && (m_starve == STARVE_MAX || !dm_req)) e_if = 1;
            else if (dm_req) e_dm = 1;
            if (e_if && if_adr < DEPTH) e_a = if_adr;
            if (e_dm && dm_adr < DEPTH) begin
               e_a = dm_adr;
               if (dm_we) begin e_we = 1; e_wd = dm_wd; end
            end
         end
      end
      check("ld_gnt", 32'(ld_gnt), 32'(e_ld));
      check("if_gnt", 32'(if_gnt), 32'(e_if));
      check("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      check("mem_a", mem_a, e_a);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_wd", mem_wd, e_wd);
      check("mem_instr_en", 32'(mem_instr_en), 32'(e_ien));
      check("mem_mem_adr", mem_mem_adr, e_madr);
      check("mem_mem_in", mem_mem_in, e_min);
      rv_ok = !res;
      check("if_rvalid", 32'(if_rvalid), 32'(m_if_rv && rv_ok));
      check("if_rdata", if_rdata, (m_if_rv && rv_ok) ? m_rdata : 32'h0);
      check("dm_rvalid", 32'(dm_rvalid), 32'(m_dm_rv && rv_ok));
      check("dm_rdata", dm_rdata, (m_dm_rv && rv_ok) ? m_rdata : 32'h0);
      check("running", 32'(running), 32'(m_run));
      check("adr_err", 32'(adr_err), 32'(m_err));
      if (res) begin
         m_run = 0; m_err = 0; m_starve = 0; m_if_rv = 0; m_dm_rv = 0;
      end else begin
         radr    = e_if ? if_adr : dm_adr;
         m_if_rv = e_if;
         m_dm_rv = e_dm && !dm_we;
         m_rdata = (radr < DEPTH) ? ref_mem[radr[6:0]] : 32'h0;
         if (e_ld && ld_adr < DEPTH) ref_mem[ld_adr[6:0]] = ld_data;
         if (e_dm && dm_we && dm_adr < DEPTH) ref_mem[dm_adr[6:0]] = dm_wd;
         if ((e_ld && ld_adr >= DEPTH) || (e_if && if_adr >= DEPTH) || (e_dm && dm_adr >= DEPTH))
            m_err = 1;
         if (m_run) begin
            if (e_if || !if_req) m_starve = 0;
            else if (e_dm && m_starve < STARVE_MAX) m_starve++;
         end else if (boot_done) begin
            m_run = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 0; ref_mem[i] = 0; end
      m_run = 0; m_err = 0; m_if_rv = 0; m_dm_rv = 0; m_starve = 0; m_rdata = 0;
      set_idle();
      @(negedge clk);
      res = 1;
      tick();
      tick();

      // boot: fill memory, fetch requests must be ignored, 0..3 get A0..A3 last
      for (int i = 0; i < DEPTH; i++) begin
         set_idle();
         ld_req  = 1;
         ld_adr  = (i < DEPTH - 4) ? 32'(i + 4) : 32'(i - (DEPTH - 4));
         ld_data = (i < DEPTH - 4) ? $urandom : 32'hA0 + ld_adr;
         if_req  = 1;
         if_adr  = 2;
         boot_done = (i == DEPTH - 1);
         tick();
      end
      set_idle();
      check("t1_running", 32'(running), 32'h1);
      tick();

      // single fetch from address 2
      if_req = 1; if_adr = 2;
      tick();
      set_idle();
      check("t2_if_rvalid", 32'(if_rvalid), 32'h1);
      check("t2_if_rdata", if_rdata, 32'hA2);
      check("t2_dm_rvalid", 32'(dm_rvalid), 32'h0);
      tick();

      // starvation: four data wins, then fetch forced through, then data again
      for (int i = 0; i < 7; i++) begin
         if_req = 1; if_adr = 3; dm_req = 1; dm_we = 0; dm_adr = 1;
         #1 check("t3_if_gnt", 32'(if_gnt), 32'(i == 4));
         tick();
      end
      set_idle();
      tick();

      // store then load back
      dm_req = 1; dm_we = 1; dm_adr = 11; dm_wd = 32'hDEADBEEF;
      #1 check("t4_mem_we", 32'(mem_we), 32'h1);
      tick();
      dm_we = 0;
      tick();
      set_idle();
      check("t4_dm_rvalid", 32'(dm_rvalid), 32'h1);
      check("t4_dm_rdata", dm_rdata, 32'hDEADBEEF);
      tick();

      // out-of-range load, loader ignored in RUN
      dm_req = 1; dm_adr = DEPTH;
      #1 check("t5_dm_gnt", 32'(dm_gnt), 32'h1);
      check("t5_mem_a", mem_a, 32'h0);
      tick();
      set_idle();
      ld_req = 1; ld_adr = 7;
      #1 check("t5_ld_gnt", 32'(ld_gnt), 32'h0);
      check("t5_dm_rvalid", 32'(dm_rvalid), 32'h1);
      check("t5_dm_rdata", dm_rdata, 32'h0);
      check("t5_adr_err", 32'(adr_err), 32'h1);
      tick();
      set_idle();
      check("t5_adr_err_sticky", 32'(adr_err), 32'h1);
      tick();

      // reset right after a granted fetch
      if_req = 1; if_adr = 5;
      tick();
      set_idle();
      res = 1;
      #1 check("t6_if_rvalid", 32'(if_rvalid), 32'h0);
      tick();
      set_idle();
      check("t6_running", 32'(running), 32'h0);
      check("t6_adr_err", 32'(adr_err), 32'h0);
      check("t6_if_rvalid_after", 32'(if_rvalid), 32'h0);
      tick();

      // random traffic across boot, run and occasional resets
      for (int i = 0; i < 3000; i++) begin
         res       = ($urandom_range(0, 79) == 0);
         boot_done = ($urandom_range(0, 7) == 0);
         ld_req    = 1'($urandom);
         ld_adr    = $urandom_range(0, DEPTH + 3);
         ld_data   = $urandom;
         if_req    = ($urandom_range(0, 3) != 0);
         if_adr    = $urandom_range(0, DEPTH + 3);
         dm_req    = 1'($urandom);
         dm_we     = 1'($urandom);
         dm_adr    = $urandom_range(0, DEPTH + 3);
         dm_wd     = $urandom;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Sequences and shares the single-port unified instruction/data memory of the micro MIPS core.
- Three requesters use the memory:
  - a boot loader, which preloads the program through the memory's load port;
  - instruction fetch;
  - data load/store.
- The block runs a BOOT→RUN state machine, arbitrates one access per cycle with starvation protection for fetch, and routes the memory's registered read data back to the requester that issued the read.

Parameters:
- MEM_DEPTH, 100: number of 32-bit words; valid addresses are 0..MEM_DEPTH-1.
- STARVE_MAX, 4: consecutive data-over-fetch wins before fetch is forced through.
- CNT_W, 3: width of the starvation counter; must hold STARVE_MAX.

Ports:
clk  in  1  system clock, rising edge
res  in  1  reset, synchronous, active-high
ld_req  in  1  loader write request
ld_adr  in  32  loader word address
ld_data  in  32  loader write data
boot_done  in  1  loader finished; pulse
ld_gnt  out  1  loader write accepted this cycle
if_req  in  1  fetch read request
if_adr  in  32  fetch word address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  32  fetch data
dm_req  in  1  data request
dm_we  in  1  1=store, 0=load
dm_adr  in  32  data word address
dm_wd  in  32  store data
dm_gnt  out  1  data access accepted this cycle
dm_rvalid  out  1  load data valid
dm_rdata  out  32  load data
mem_a  out  32  memory run-mode address
mem_wd  out  32  memory run-mode write data
mem_we  out  1  memory run-mode write enable
mem_instr_en  out  1  memory load-port enable
mem_mem_adr  out  32  memory load-port address
mem_mem_in  out  32  memory load-port data
mem_rd  in  32  memory registered read data (1-cycle latency)
running  out  1  state==RUN
adr_err  out  1  sticky out-of-range flag

Behaviour:
- Reset (res=1 at a clk edge):
  - state=BOOT, starve_cnt=0, adr_err=0, if_rvalid=0, dm_rvalid=0, running=0.
  - While res=1, all gnt and mem_* enables are 0 and all mem_* buses are 0.
  - Reset mid-operation abandons any outstanding read: no rvalid follows.
- Grants and memory command outputs are combinational from the current state and the requests. The memory samples the command on the next clk edge.
- Idle cycles: mem_we=0, mem_instr_en=0, mem_a=0, all data buses 0.
- BOOT state:
  - ld_gnt=ld_req. When ld_req=1: mem_instr_en=1, mem_mem_adr=ld_adr, mem_mem_in=ld_data.
  - if_gnt=dm_gnt=0.
  - boot_done=1 moves BOOT→RUN at the next edge. A same-cycle ld_req is still granted and written.
- RUN state:
  - ld_gnt=0; ld_req and boot_done are ignored.
  - Only res returns the block to BOOT.
  - Priority is data over fetch, except when starve_cnt==STARVE_MAX, in which case fetch wins.
  - At most one grant per cycle.
- Starvation counter (RUN):
  - Increments when dm_gnt=1 while if_req=1.
  - Clears when if_gnt=1 or if_req=0.
  - Saturates at STARVE_MAX.
- Granted data store: mem_a=dm_adr, mem_wd=dm_wd, mem_we=1. No rvalid is produced.
- Granted read, fetch or data: mem_a=adr, mem_we=0.
  - The matching rvalid is registered high for exactly one cycle, one cycle after the grant.
  - rdata=mem_rd while rvalid=1, else 0.
  - Back-to-back reads produce back-to-back rvalids, each tagged to the requester granted one cycle earlier.
- Out-of-range access (adr >= MEM_DEPTH), any requester:
  - The request is still granted (consumed), but no memory enable is driven: mem_we=0, mem_instr_en=0, mem_a=0.
  - adr_err is set and stays set until res.
  - A read still returns rvalid next cycle with rdata=0.
- Ungranted requesters hold their request; the arbiter keeps no queue.

Test Plan:
1. Reset, then ld_req with ld_adr=0..3 and data 0xA0..0xA3, boot_done with the last write → four mem_instr_en pulses with matching adr/data, ld_gnt each cycle; running=1 after the edge; if_gnt=0 throughout BOOT.
2. RUN, if_req with if_adr=2 alone → if_gnt same cycle, mem_a=2, next cycle if_rvalid=1 and if_rdata=0xA2; dm_rvalid stays 0.
3. RUN, if_req and dm_req (load, adr=1) held continuously → dm_gnt for 4 cycles, then if_gnt on the 5th; starve_cnt returns to 0; rvalids alternate correctly, each one cycle after its grant.
4. dm store adr=11 wd=0xDEADBEEF, then dm load adr=11 → mem_we=1 for one cycle, then dm_rvalid=1 with dm_rdata=0xDEADBEEF.
5. dm load adr=100 (MEM_DEPTH=100) → dm_gnt=1, mem_we=0, mem_a=0; next cycle dm_rvalid=1 with dm_rdata=0; adr_err=1 and sticky; ld_req in RUN → ld_gnt=0.
6. Assert res one cycle after a granted fetch → no if_rvalid; state=BOOT, adr_err=0, running=0.
